fft_mem_sequencer: RTL

Control sequencer for the in-place radix-2 DIT FFT. It owns both ports of the 1024-entry complex dual-port RAM and runs three phases after `start`:
- load a streamed frame in bit-reversed order;
- run all N_LOG2 butterfly stages through an external fixed-latency butterfly unit;
- stream the result out in natural order.

It sits between the sample stream front end, the RAM and the butterfly/twiddle datapath.

---
 rtl/fft_consts.sv | 44 ++++
 rtl/fft_bf_addr_gen.sv | 34 +++
 rtl/fft_mem_sequencer.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/fft_consts.sv
// Shared constants, types and helpers for the in-place radix-2 DIT FFT.
//   N_LOG2, N       : default transform size (log2 and points)
//   complex_t       : one RAM word, signed 16-bit real / imaginary halves
//   DW_COMPLEX      : width of complex_t
//   fft_seq_state_t : sequencer FSM states; the UNL_* states exist only when
//                     FFT_SEQ_UNLOAD_EN is defined, otherwise ST_FIN replaces them
//   bitrev()        : reverse the low n_log2 bits of an index (n_log2 <= 16)
package fft_consts;

  localparam int N_LOG2 = 10;
  localparam int N      = 1 << N_LOG2;

  typedef struct packed {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } complex_t;

  localparam int DW_COMPLEX = $bits(complex_t);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_BF_RD,
    ST_BF_WAIT,
    ST_BF_WR,
`ifdef FFT_SEQ_UNLOAD_EN
    ST_UNL_RD,
    ST_UNL_WAIT,
    ST_UNL_OUT
`else
    ST_FIN
`endif
  } fft_seq_state_t;

  function automatic logic [15:0] bitrev(input logic [15:0] v, input int n_log2);
    logic [15:0] r;
    r = '0;
    for (int b = 0; b < 16; b++) begin
      if (b < n_log2) r[b] = v[n_log2-1-b];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_bf_addr_gen.sv
// Butterfly address generator for one radix-2 DIT pass (purely combinational).
//   stg    in  : stage number s, 0..N_LOG2-1
//   bfk    in  : butterfly index k within the stage, 0..N/2-1
//   top    out : address of the upper operand
//   bot    out : address of the lower operand (top + 2^s)
//   tw_idx out : twiddle ROM index for this butterfly
module fft_bf_addr_gen #(
  parameter int N_LOG2 = fft_consts::N_LOG2
) (
  input  logic [$clog2(N_LOG2+1)-1:0] stg,
  input  logic [N_LOG2-2:0]           bfk,
  output logic [N_LOG2-1:0]           top,
  output logic [N_LOG2-1:0]           bot,
  output logic [N_LOG2-2:0]           tw_idx
);

  localparam int SW = $clog2(N_LOG2+1);

  logic [N_LOG2-1:0] k_ext;
  logic [N_LOG2-1:0] span;
  logic [N_LOG2-1:0] j;

  always_comb begin
    k_ext  = {1'b0, bfk};
    span   = N_LOG2'(1) << stg;
    j      = k_ext & (span - N_LOG2'(1));
    // insert a zero bit at position s: groups of 2*span, offset j inside the group
    top    = ((k_ext >> stg) << (stg + SW'(1))) | j;
    bot    = top + span;
    // j < span <= N/2, so the shifted index always fits in N_LOG2-1 bits
    tw_idx = j[N_LOG2-2:0] << (SW'(N_LOG2-1) - stg);
  end

endmodule

// File: rtl/fft_mem_sequencer.sv
// FFT memory sequencer: loads a streamed frame into the dual-port RAM in
// bit-reversed order, runs every butterfly stage in place through an external
// fixed-latency butterfly unit, then (optionally) streams the result out.
// Build option: FFT_SEQ_UNLOAD_EN adds the unload phase; without it done pulses
// after the last butterfly write and the frame is left in RAM.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   start / busy / done      frame control and status
//   s_valid/s_ready/s_data   input sample stream (accepted in LOAD only)
//   m_valid/m_ready/m_data   output sample stream (unload build only)
//   ena/wea/addra/dina/douta RAM port A (1-cycle read latency)
//   enb/web/addrb/dinb/doutb RAM port B (compute only)
//   bf_valid/bf_a/bf_b/bf_tw_idx  operands to butterfly unit
//   bf_x/bf_y                butterfly results, BF_LAT cycles after bf_valid
//
// state       | meaning
// ST_IDLE     | waiting for start
// ST_LOAD     | accepting samples, writing to bitrev(i)
// ST_BF_RD    | reading top/bottom operands on ports A/B
// ST_BF_WAIT  | operands presented, waiting out butterfly latency
// ST_BF_WR    | writing bf_x/bf_y back to top/bottom
// ST_UNL_RD   | reading result word i on port A
// ST_UNL_WAIT | capturing read data into m_data
// ST_UNL_OUT  | holding m_valid until m_ready
// ST_FIN      | done pulse when unload is compiled out
module fft_mem_sequencer #(
  parameter int N_LOG2 = fft_consts::N_LOG2,
  parameter int DWC    = fft_consts::DW_COMPLEX,
  parameter int BF_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DWC-1:0]    s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DWC-1:0]    m_data,
  output logic              ena,
  output logic              wea,
  output logic [N_LOG2-1:0] addra,
  output logic [DWC-1:0]    dina,
  input  logic [DWC-1:0]    douta,
  output logic              enb,
  output logic              web,
  output logic [N_LOG2-1:0] addrb,
  output logic [DWC-1:0]    dinb,
  input  logic [DWC-1:0]    doutb,
  output logic              bf_valid,
  output logic [DWC-1:0]    bf_a,
  output logic [DWC-1:0]    bf_b,
  output logic [N_LOG2-2:0] bf_tw_idx,
  input  logic [DWC-1:0]    bf_x,
  input  logic [DWC-1:0]    bf_y
);

  import fft_consts::*;

  localparam int SW = $clog2(N_LOG2+1);
  localparam int KW = N_LOG2-1;
  localparam int WW = $clog2(BF_LAT+1);
  localparam logic [SW-1:0] LAST_STG = SW'(N_LOG2-1);

  fft_seq_state_t state, state_nxt;

  logic [N_LOG2-1:0] idx;
  logic [SW-1:0]     stg;
  logic [KW-1:0]     bfk;
  logic [WW-1:0]     wait_cnt;
  logic              bf_valid_q;
  logic [KW-1:0]     tw_q;

  logic [N_LOG2-1:0] top, bot;
  logic [KW-1:0]     tw;
  logic [15:0]       rev_full;
  logic [N_LOG2-1:0] idx_rev;
  logic              unused_rev_hi;
  logic              last_bf;

  fft_bf_addr_gen #(.N_LOG2(N_LOG2)) u_addr_gen (
    .stg    (stg),
    .bfk    (bfk),
    .top    (top),
    .bot    (bot),
    .tw_idx (tw)
  );

  assign rev_full      = bitrev(16'(idx), N_LOG2);
  assign idx_rev       = rev_full[N_LOG2-1:0];
  assign unused_rev_hi = ^rev_full[15:N_LOG2];
  assign last_bf       = (&bfk) && (stg == LAST_STG);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      stg        <= '0;
      bfk        <= '0;
      wait_cnt   <= '0;
      bf_valid_q <= 1'b0;
      tw_q       <= '0;
    end else begin
      state      <= state_nxt;
      bf_valid_q <= (state == ST_BF_RD);
      case (state)
        ST_IDLE: begin
          if (start) begin
            idx <= '0;
            stg <= '0;
            bfk <= '0;
          end
        end
        // idx wraps to 0 after N-1, ready for the unload pass
        ST_LOAD:    if (s_valid) idx <= idx + N_LOG2'(1);
        ST_BF_RD: begin
          tw_q     <= tw;
          wait_cnt <= WW'(BF_LAT-1);
        end
        ST_BF_WAIT: if (wait_cnt != '0) wait_cnt <= wait_cnt - WW'(1);
        ST_BF_WR: begin
          bfk <= bfk + KW'(1);
          if (&bfk) stg <= (stg == LAST_STG) ? '0 : stg + SW'(1);
        end
`ifdef FFT_SEQ_UNLOAD_EN
        ST_UNL_OUT: if (m_ready) idx <= idx + N_LOG2'(1);
`endif
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state != ST_IDLE);
    done      = 1'b0;
    s_ready   = 1'b0;
    m_valid   = 1'b0;
    ena       = 1'b0;
    wea       = 1'b0;
    addra     = '0;
    dina      = '0;
    enb       = 1'b0;
    web       = 1'b0;
    addrb     = '0;
    dinb      = '0;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_LOAD;
      ST_LOAD: begin
        s_ready = 1'b1;
        addra   = idx_rev;
        dina    = s_data;
        if (s_valid) begin
          ena = 1'b1;
          wea = 1'b1;
          if (&idx) state_nxt = ST_BF_RD;
        end
      end
      ST_BF_RD: begin
        ena       = 1'b1;
        enb       = 1'b1;
        addra     = top;
        addrb     = bot;
        state_nxt = ST_BF_WAIT;
      end
      ST_BF_WAIT: begin
        addra = top;
        addrb = bot;
        if (wait_cnt == '0) state_nxt = ST_BF_WR;
      end
      ST_BF_WR: begin
        ena   = 1'b1;
        wea   = 1'b1;
        enb   = 1'b1;
        web   = 1'b1;
        addra = top;
        addrb = bot;
        dina  = bf_x;
        dinb  = bf_y;
`ifdef FFT_SEQ_UNLOAD_EN
        state_nxt = last_bf ? ST_UNL_RD : ST_BF_RD;
`else
        state_nxt = last_bf ? ST_FIN : ST_BF_RD;
`endif
      end
`ifdef FFT_SEQ_UNLOAD_EN
      ST_UNL_RD: begin
        ena       = 1'b1;
        addra     = idx;
        state_nxt = ST_UNL_WAIT;
      end
      ST_UNL_WAIT: state_nxt = ST_UNL_OUT;
      ST_UNL_OUT: begin
        m_valid = 1'b1;
        if (m_ready) begin
          if (&idx) begin
            done      = 1'b1;
            state_nxt = ST_IDLE;
          end else begin
            state_nxt = ST_UNL_RD;
          end
        end
      end
`else
      ST_FIN: begin
        done      = 1'b1;
        state_nxt = ST_IDLE;
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // operands go straight from RAM read data to the butterfly; zero when idle
  assign bf_valid  = bf_valid_q;
  assign bf_a      = bf_valid_q ? douta : '0;
  assign bf_b      = bf_valid_q ? doutb : '0;
  assign bf_tw_idx = tw_q;

`ifdef FFT_SEQ_UNLOAD_EN
  logic [DWC-1:0] m_data_q;

  always_ff @(posedge clk) begin
    if (rst) m_data_q <= '0;
    else if (state == ST_UNL_WAIT) m_data_q <= douta;
  end

  assign m_data = m_data_q;
`else
  logic unused_m_ready;

  assign m_data         = '0;
  assign unused_m_ready = m_ready;
`endif

endmodule
